// File: rtl/muldiv_pkg.sv
// Definitions shared by the multicycle MIPS multiply/divide units.
// Holds the control-state encoding, the widths and the start/done handshake levels.
package muldiv_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Both units launch on a rising start and answer with a one-cycle done pulse.
    localparam logic START_ACTIVE = 1'b1;
    localparam logic DONE_ACTIVE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration on unsigned magnitudes.
// It shifts {rem, dvd} left by one and tries to subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // rem < divisor <= 2^(WIDTH-1), so one extra bit holds both the shifted value and the trial sign.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], q_bit};

endmodule

// File: rtl/radix2_divider.sv
// Sequential signed divider for DIV: one quotient bit per clock on the operand magnitudes.
// The result signs are fixed up when the outputs load. The quotient truncates toward zero.
module radix2_divider
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             launch;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd      (dvd_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    // The most negative value maps onto its own bit pattern, which is the correct unsigned magnitude.
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign launch = (state_q == IDLE) && (start == START_ACTIVE) && (start_q != START_ACTIVE);

    always_comb begin
        state_d       = state_q;
        start_d       = start;
        dvd_d         = dvd_q;
        rem_d         = rem_q;
        divisor_d     = divisor_q;
        cnt_d         = cnt_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        done_d        = ~DONE_ACTIVE;
        div_by_zero_d = div_by_zero_q;
        busy_d        = busy_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    dvd_d         = a_mag;
                    divisor_d     = b_mag;
                    rem_d         = '0;
                    cnt_d         = '0;
                    neg_quo_d     = a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_d     = a[WIDTH-1];
                    div_by_zero_d = 1'b0;
                    if (b == '0) begin
                        state_d       = DONE;
                        quotient_d    = '0;
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        busy_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = neg_quo_q ? -step_dvd : step_dvd;
                    remainder_d = neg_rem_q ? -step_rem : step_rem;
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = DONE_ACTIVE;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                // A zero divisor enters DONE straight from IDLE, so the pulse is raised one edge later.
                if (done_q == DONE_ACTIVE) begin
                    state_d = IDLE;
                end else begin
                    done_d = DONE_ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            dvd_q         <= '0;
            rem_q         <= '0;
            divisor_q     <= '0;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            dvd_q         <= dvd_d;
            rem_q         <= rem_d;
            divisor_q     <= divisor_d;
            cnt_q         <= cnt_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_radix2_divider.sv
// Directed and random checks of radix2_divider against a plain-arithmetic signed division model.
module tb_radix2_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        div_by_zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    radix2_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset_n),
        .a           (a),
        .b           (b),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Signed division with truncation toward zero, computed at 64 bits so -2^31 / -1 is well defined.
    task automatic ref_div(input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, qa, ra;
        if (bv == 32'd0) begin
            q = 32'd0; r = 32'd0; dz = 1'b1;
        end else begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            qa = sa / sb;
            ra = sa % sb;
            q  = qa[31:0];
            r  = ra[31:0];
            dz = 1'b0;
        end
    endtask

    // Launch one division and check latency, result, pulse width and hold.
    // glitch: pulse start and scramble a/b around cycle 10 of BUSY.
    task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input bit glitch);
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        bit          got;
        ref_div(av, bv, eq, er, edz);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_launch"}, {31'd0, busy}, {31'd0, ~edz});
        lat = 0;
        got = 1'b0;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (glitch && n == 10) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            if (glitch && n == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk({tag, "_latency"}, lat, edz ? 32'd1 : 32'd32);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        $display("op %s a=%h b=%h q=%h r=%h dz=%b lat=%0d", tag, av, bv, quotient, remainder,
                 div_by_zero, lat);
        @(posedge clk); #1;
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
        chk({tag, "_q_held"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] eq, er, av, bv;
        logic        edz;
        int          pulses;

        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {29'd0, done, div_by_zero, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_div("p100_7", 32'd100, 32'd7, 1'b0);
        do_div("m100_7", 32'hFFFFFF9C, 32'd7, 1'b0);
        do_div("p100_m7", 32'd100, 32'hFFFFFFF9, 1'b0);
        do_div("div0", 32'd7, 32'd0, 1'b0);
        do_div("after_div0", 32'd7, 32'd3, 1'b0);
        do_div("min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_div("min_1", 32'h80000000, 32'd1, 1'b0);
        do_div("glitch", 32'd12345, 32'hFFFFFF85, 1'b1);

        // start held high for 40 cycles must launch exactly once
        ref_div(32'd1000, 32'd33, eq, er, edz);
        @(negedge clk);
        a = 32'd1000; b = 32'd33; start = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("hold_pulses", pulses, 32'd1);
        chk("hold_quotient", quotient, eq);
        chk("hold_remainder", remainder, er);
        $display("op hold a=%h b=%h q=%h r=%h pulses=%0d", 32'd1000, 32'd33, quotient, remainder,
                 pulses);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        $display("op async_reset q=%h r=%h busy=%b", quotient, remainder, busy);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_div("after_rst_9_2", 32'd9, 32'd2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            av = $urandom;
            case ($urandom_range(0, 3))
                0: bv = $urandom;
                1: bv = $urandom_range(1, 300);
                2: bv = -$urandom_range(1, 300);
                default: bv = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            do_div($sformatf("rand%0d", i), av, bv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/radix2_divider.md
Name: radix2_divider

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS core, serving DIV.
- Sits between operand registers A/B (dividend/divisor) and the HI/LO register pair.
- The control FSM pulses or holds start, then waits on done.
- The datapath then writes remainder to HI and quotient to LO.
- Restoring radix-2 algorithm on magnitudes, with sign fix-up; one quotient bit per clock.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
a  input  WIDTH  signed dividend; sampled only at launch
b  input  WIDTH  signed divisor; sampled only at launch
start  input  1  request; a launch occurs on its rising edge
quotient  output  WIDTH  signed quotient, registered, held until next launch
remainder  output  WIDTH  signed remainder, registered, held until next launch
done  output  1  one-cycle completion pulse, registered
div_by_zero  output  1  registered flag; valid from done, held until next launch
busy  output  1  high while in BUSY

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; quotient, remainder, done, div_by_zero, busy all 0.
  - internal start_q=0.
  - Takes effect mid-operation; any in-flight result is discarded.
- Launch condition: state==IDLE && start==1 && start_q==0.
  - start_q is start registered every cycle.
  - A start held high launches exactly once.
  - start edges in BUSY or DONE are ignored, and not queued.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - On launch, latch |a| and |b| into divisor/working registers.
  - Latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
  - Clear remainder accumulator; cnt=0; clear div_by_zero.
  - b==0: go directly to DONE. Load quotient=0, remainder=0, div_by_zero=1.
  - Otherwise go to BUSY; busy=1.
- BUSY, each cycle:
  - Shift {rem, dvd} left 1.
  - trial = rem_shifted - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, new quotient LSB = 1. Else keep rem, LSB = 0.
  - cnt++.
  - On the cycle with cnt==WIDTH-1, also load output registers:
    - quotient = sign_q ? -q : q
    - remainder = sign_r ? -r : r
  - Then go to DONE.
- DONE: done=1 for exactly this one cycle; busy=0; then unconditionally go to IDLE.
- Latency, counting clock edges after the launch edge E0:
  - Normal: done is high during the cycle after edge E(WIDTH), i.e. edge 32 for WIDTH=32.
  - Divide-by-zero: done is high after E1.
  - The earliest relaunch is the edge ending DONE plus one cycle, which requires start to have dropped first.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - |x| of -2^(W-1) is 2^(W-1) as unsigned; magnitudes are kept at WIDTH bits unsigned.
  - Overflow case -2^31 / -1 yields quotient=0x80000000, remainder=0. No flag is raised.
- Outputs do not change outside the load edge; quotient/remainder stay stable for HI/LO write at any later cycle.
- a and b may change freely after launch without affecting the result.

Decomposition:
- Shared package muldiv_pkg contains:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - DIV_WIDTH=32
  - counter width localparam $clog2(WIDTH)
  - the same done/start handshake constants as the multiplier uses
- Sub-module div_step, purely combinational, performs one restoring iteration:
  - inputs: rem, dvd, divisor
  - outputs: rem_next, dvd_next with the quotient bit inserted
- Keep the FSM, counter and sign fix-up in radix2_divider.

Test Plan:
- a=100, b=7, start pulse → done high exactly 32 cycles after launch edge; quotient=14, remainder=2, div_by_zero=0.
- a=-100 (0xFFFFFF9C), b=7 → quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); a=100, b=-7 → quotient=-14, remainder=2.
- a=7, b=0 → done one cycle after launch; quotient=0, remainder=0, div_by_zero=1; the next launch with b=3 clears the flag.
- a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0; a=0x80000000, b=1 → quotient=0x80000000, remainder=0.
- Handshake:
  - start held high for 40 cycles → exactly one done pulse.
  - An extra start pulse at cycle 10 of BUSY → ignored; result unchanged.
  - a/b changed mid-BUSY → result unchanged.
- reset driven 0 at cycle 15 of a 100/7 operation → outputs 0, busy=0 immediately (asynchronous). After release, launch 9/2 → quotient=4, remainder=1 with normal latency.
